// File: rtl/alu_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// alu_arbiter_pkg
// Purpose : Shared constants for the ALU request arbiter and its consumers.
//           Holds the ALU datapath widths, the ALUControl operation codes,
//           and the response-buffer occupancy states.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR    = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD   = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SUB   = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_PASSB = 4'b0111;

    // The response buffer is the only state; EMPTY always accepts a new op,
    // FULL accepts one only when the consumer drains in the same cycle.
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purpose : Purely combinational round-robin picker. Starting at i_ptr and
//           wrapping at NREQ-1 -> 0, selects the first requester whose bit is
//           set in i_req.
// Ports   : i_req   [NREQ-1:0]  request vector
//           i_ptr   [IDW-1:0]   highest-priority index for this cycle
//           o_grant [NREQ-1:0]  one-hot grant (all zero when no request)
//           o_idx   [IDW-1:0]   binary index of the grant (0 when none)
//           o_any               at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    // Walk the requesters in priority order; the first hit wins and later
    // hits are masked by w_found so the grant stays one-hot.
    always_comb begin
        int   w_pos;
        logic w_found;
        w_pos   = 0;
        w_found = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = (int'(i_ptr) + k) % NREQ;
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = IDW'(w_pos);
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Purpose : Shares one external 64-bit ALU between NREQ requesters. A round-
//           robin grant steers the winner's operands onto the ALU inputs in
//           the same cycle; the ALU result and zero flag are captured into a
//           one-entry response buffer tagged with the requester id.
// Ports   : clk, reset_n                   clock, async active-low reset
//           req_valid/req_ready [NREQ]     per-requester handshake
//           req_a/req_b [NREQ*64]          operands, requester i at [64*i +: 64]
//           req_op [NREQ*4]                ALUControl, requester i at [4*i +: 4]
//           alu_a/alu_b/alu_ctrl           drive the external ALU
//           alu_result/alu_zero            returned by the external ALU
//           rsp_valid/rsp_ready            response handshake
//           rsp_id/rsp_result/rsp_zero     captured response
//           ops_count [CNTW]               accepted requests, wraps
// ----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*CTRL_W-1:0] req_op,
    output logic [NREQ-1:0]        req_ready,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [CTRL_W-1:0]      alu_ctrl,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic                   alu_zero,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_result,
    output logic                   rsp_zero,
    input  logic                   rsp_ready,
    output logic [CNTW-1:0]        ops_count
);

    logic [IDW-1:0]    r_ptr;
    logic              r_rsp_valid;
    logic [IDW-1:0]    r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero;
    logic [CNTW-1:0]   r_ops_count;

    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_idx;
    logic              w_any;
    logic              w_can_issue;
    logic              w_issue;
    logic [IDW-1:0]    w_ptr_next;
    rsp_state_e        w_state;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_state = r_rsp_valid ? RSP_FULL : RSP_EMPTY;

    // reset_n gates issue directly so req_ready and the ALU inputs read zero
    // for the whole time reset is held, not just after the next edge.
    assign w_can_issue = reset_n && ((w_state == RSP_EMPTY) || rsp_ready);
    assign w_issue     = w_can_issue && w_any;
    assign req_ready   = w_issue ? w_grant : '0;

    // Explicit wrap keeps the pointer inside 0..NREQ-1 for non-power-of-two NREQ.
    assign w_ptr_next = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;

    // Operand steering: the granted requester's fields go to the ALU, and
    // an idle cycle presents AND of zeros so the ALU inputs are quiet.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (w_issue) begin
            alu_a    = req_a[int'(w_idx)*DATA_W +: DATA_W];
            alu_b    = req_b[int'(w_idx)*DATA_W +: DATA_W];
            alu_ctrl = req_op[int'(w_idx)*CTRL_W +: CTRL_W];
        end
    end

    // Response buffer, round-robin pointer and op counter. An issue always
    // overwrites the buffer (it is only allowed when the buffer is empty or
    // being drained); a drain without a new issue clears only the valid bit
    // so the data fields keep their last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_ops_count  <= '0;
        end else if (w_issue) begin
            r_ptr        <= w_ptr_next;
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_idx;
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
            r_ops_count  <= r_ops_count + CNTW'(1);
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign ops_count  = r_ops_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
// Purpose : Self-checking bench for alu_arbiter. A behavioural ALU sits on the
//           alu_* interface; every observed handshake pushes the expected
//           response (computed from the requester's own fields) onto a queue
//           that is popped when the response should be visible. A second
//           instance with a 3-bit counter exercises ops_count wrap-around.
// Ports   : none (top-level bench)
// ----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] res;
        logic        z;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic [3:0]    req_valid;
    logic [255:0]  req_a;
    logic [255:0]  req_b;
    logic [15:0]   req_op;
    logic [3:0]    req_ready;
    logic [63:0]   alu_a;
    logic [63:0]   alu_b;
    logic [3:0]    alu_ctrl;
    logic [63:0]   alu_result;
    logic          alu_zero;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [63:0]   rsp_result;
    logic          rsp_zero;
    logic          rsp_ready;
    logic [31:0]   ops_count;

    logic [3:0]    s_req_ready;
    logic [63:0]   s_alu_a;
    logic [63:0]   s_alu_b;
    logic [3:0]    s_alu_ctrl;
    logic [63:0]   s_alu_result;
    logic          s_alu_zero;
    logic          s_rsp_valid;
    logic [1:0]    s_rsp_id;
    logic [63:0]   s_rsp_result;
    logic          s_rsp_zero;
    logic [2:0]    s_ops_count;

    int   checks;
    int   errors;
    int   ops_m;
    int   ptr_m;
    exp_t sbq[$];

    function automatic logic [63:0] alu_model(input logic [63:0] a,
                                              input logic [63:0] b,
                                              input logic [3:0]  op);
        case (op)
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_PASSB: return b;
            default:   return a;
        endcase
    endfunction

    // External ALU stand-ins for both instances.
    assign alu_result   = alu_model(alu_a, alu_b, alu_ctrl);
    assign alu_zero     = (alu_result == 64'd0);
    assign s_alu_result = alu_model(s_alu_a, s_alu_b, s_alu_ctrl);
    assign s_alu_zero   = (s_alu_result == 64'd0);

    alu_arbiter #(.NREQ(4), .IDW(2), .CNTW(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_ready  (rsp_ready),
        .ops_count  (ops_count)
    );

    alu_arbiter #(.NREQ(4), .IDW(2), .CNTW(3)) dut_small (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_ready  (s_req_ready),
        .alu_a      (s_alu_a),
        .alu_b      (s_alu_b),
        .alu_ctrl   (s_alu_ctrl),
        .alu_result (s_alu_result),
        .alu_zero   (s_alu_zero),
        .rsp_valid  (s_rsp_valid),
        .rsp_id     (s_rsp_id),
        .rsp_result (s_rsp_result),
        .rsp_zero   (s_rsp_zero),
        .rsp_ready  (rsp_ready),
        .ops_count  (s_ops_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_req(input int i, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] op);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
        req_op[4*i +: 4]  = op;
    endtask

    task automatic set_all_fields();
        set_req(0, 64'd100, 64'd1,  ALU_ADD);
        set_req(1, 64'd101, 64'd11, ALU_SUB);
        set_req(2, 64'hF0,  64'h0F, ALU_OR);
        set_req(3, 64'hFF,  64'h3C, ALU_AND);
    endtask

    // Called at the sampling edge: queues the expected response for every
    // handshake seen and advances the bench's own pointer and op count.
    task automatic applyStimulus();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id  = 2'(i);
                e.res = alu_model(req_a[64*i +: 64], req_b[64*i +: 64], req_op[4*i +: 4]);
                e.z   = (e.res == 64'd0);
                sbq.push_back(e);
                ops_m = ops_m + 1;
                ptr_m = (i + 1) % 4;
            end
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        sbq.delete();
        ops_m = 0;
        ptr_m = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        set_all_fields();
        req_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== 68'd0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got %h, expected 0", {rsp_valid, rsp_id, rsp_result, rsp_zero});
        end
        checks++;
        if (ops_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_ops: got %0d, expected 0", ops_count);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, expected 0000", req_ready);
        end
        checks++;
        if ({alu_a, alu_b, alu_ctrl} !== 132'd0) begin
            errors++;
            $display("[TB] FAIL reset_alu: got %h, expected 0", {alu_a, alu_b, alu_ctrl});
        end
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        req_valid = 4'b0000;
        sbq.delete();
        ops_m = 0;
        ptr_m = 0;
    endtask

    task automatic test_single();
        exp_t e;
        set_req(0, 64'd5, 64'd3, ALU_ADD);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL single_ready: got %b, expected 0001", req_ready);
        end
        checks++;
        if ({alu_a, alu_b, alu_ctrl} !== {64'd5, 64'd3, ALU_ADD}) begin
            errors++;
            $display("[TB] FAIL single_alu: got %h, expected %h", {alu_a, alu_b, alu_ctrl}, {64'd5, 64'd3, ALU_ADD});
        end
        applyStimulus();
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL single_rsp: got no queued entry, expected one");
        end else begin
            e = sbq.pop_front();
            if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL single_rsp: got %h, expected %h", {rsp_valid, rsp_id, rsp_result, rsp_zero}, {1'b1, e});
            end
        end
        checks++;
        if ({rsp_id, rsp_result, rsp_zero} !== {2'd0, 64'd8, 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_value: got %h, expected %h", {rsp_id, rsp_result, rsp_zero}, {2'd0, 64'd8, 1'b0});
        end
        checks++;
        if (ops_count !== 32'(ops_m)) begin
            errors++;
            $display("[TB] FAIL single_ops: got %0d, expected %0d", ops_count, ops_m);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result} !== {1'b0, 64'd8}) begin
            errors++;
            $display("[TB] FAIL single_drain: got %h, expected %h", {rsp_valid, rsp_result}, {1'b0, 64'd8});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        exp_t       e;
        logic [3:0] want;
        do_reset();
        set_all_fields();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rr_rsp: got no queued entry, expected one");
                end else begin
                    e = sbq.pop_front();
                    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, e}) begin
                        errors++;
                        $display("[TB] FAIL rr_rsp: got %h, expected %h", {rsp_valid, rsp_id, rsp_result, rsp_zero}, {1'b1, e});
                    end
                end
            end
            if (k < 5) begin
                want = 4'b0001 << ptr_m;
                checks++;
                if (req_ready !== want) begin
                    errors++;
                    $display("[TB] FAIL rr_grant%0d: got %b, expected %b", k, req_ready, want);
                end
                applyStimulus();
            end
            @(posedge clk);
            #1;
            if (k == 4) req_valid = 4'b0000;
        end
        checks++;
        if (ops_count !== 32'd5) begin
            errors++;
            $display("[TB] FAIL rr_ops: got %0d, expected 5", ops_count);
        end
    endtask

    task automatic test_back_pressure();
        exp_t e;
        do_reset();
        set_all_fields();
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL bp_first: got %b, expected 0001", req_ready);
        end
        applyStimulus();
        @(posedge clk);
        #1;
        e = sbq[0];
        for (int k = 0; k < 5; k++) begin
            req_valid = (k == 2 || k == 3) ? 4'b1101 : 4'b1111;
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL bp_stall_ready%0d: got %b, expected 0000", k, req_ready);
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got %h, expected %h", k, {rsp_valid, rsp_id, rsp_result, rsp_zero}, {1'b1, e});
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bp_resume: got %b, expected 0010", req_ready);
        end
        e = sbq.pop_front();
        applyStimulus();
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL bp_rsp: got no queued entry, expected one");
        end else begin
            e = sbq.pop_front();
            if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL bp_rsp: got %h, expected %h", {rsp_valid, rsp_id, rsp_result, rsp_zero}, {1'b1, e});
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_drain: got %b, expected 0", rsp_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_flag();
        exp_t e;
        set_req(2, 64'd7, 64'd7, ALU_SUB);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL zero_grant: got %b, expected 0100", req_ready);
        end
        applyStimulus();
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL zero_rsp: got no queued entry, expected one");
        end else begin
            e = sbq.pop_front();
            if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL zero_rsp: got %h, expected %h", {rsp_valid, rsp_id, rsp_result, rsp_zero}, {1'b1, e});
            end
        end
        checks++;
        if ({rsp_id, rsp_result, rsp_zero} !== {2'd2, 64'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL zero_value: got %h, expected %h", {rsp_id, rsp_result, rsp_zero}, {2'd2, 64'd0, 1'b1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        set_req(0, 64'd9, 64'd4, ALU_PASSB);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        @(negedge clk);
        applyStimulus();
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_pre: got %b, expected 1", rsp_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, ops_count, s_ops_count, req_ready} !== {1'b0, 32'd0, 3'd0, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL midrst_clear: got %h, expected 0", {rsp_valid, ops_count, s_ops_count, req_ready});
        end
        sbq.delete();
        ops_m = 0;
        ptr_m = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_req(3, 64'd12, 64'd2, ALU_ADD);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL midrst_grant: got %b, expected 1000", req_ready);
        end
        applyStimulus();
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL midrst_rsp: got no queued entry, expected one");
        end else begin
            e = sbq.pop_front();
            if ({rsp_valid, rsp_id, rsp_result, rsp_zero, ops_count} !== {1'b1, e, 32'd1}) begin
                errors++;
                $display("[TB] FAIL midrst_rsp: got %h, expected %h", {rsp_valid, rsp_id, rsp_result, rsp_zero, ops_count}, {1'b1, e, 32'd1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput_wrap();
        exp_t e;
        int   guard;
        set_all_fields();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        guard = 0;
        while (ops_m != 7 && guard < 20) begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++;
                if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, e}) begin
                    errors++;
                    $display("[TB] FAIL wrap_rsp: got %h, expected %h", {rsp_valid, rsp_id, rsp_result, rsp_zero}, {1'b1, e});
                end
            end
            applyStimulus();
            @(posedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
        checks++;
        if (s_ops_count !== 3'd7) begin
            errors++;
            $display("[TB] FAIL wrap_pre: got %0d, expected 7", s_ops_count);
        end
        if (sbq.size() != 0) e = sbq.pop_front();
        applyStimulus();
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (s_ops_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL wrap_small: got %0d, expected 0", s_ops_count);
        end
        checks++;
        if (ops_count !== 32'd8) begin
            errors++;
            $display("[TB] FAIL wrap_wide: got %0d, expected 8", ops_count);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ops_m     = 0;
        ptr_m     = 0;
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_zero_flag();
        test_reset_mid_op();
        checkOutput_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
